// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Helpers work at a fixed maximum width; callers keep only the low bits they need.
package mult_pkg;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   // Widest operand the helpers support (WIDTH must stay below this).
   localparam int MAX_W = 64;

   // Counter width for the default operand width; modules use cnt_width(WIDTH).
   localparam int DEF_WIDTH = 4;
   localparam int DEF_CNT_W = $clog2(DEF_WIDTH + 1);

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

   // Low w bits of the result are the w-bit absolute value of a zero-extended operand.
   function automatic logic [MAX_W-1:0] magnitude(input logic [MAX_W-1:0] v, input logic neg);
      return neg ? (~v + MAX_W'(1)) : v;
   endfunction

   function automatic logic [2*MAX_W-1:0] negate(input logic [2*MAX_W-1:0] v);
      return ~v + (2*MAX_W)'(1);
   endfunction

endpackage

// File: rtl/sumadorCompletoN.sv
// N-bit adder with carry in/out, reused every cycle by the multiplier accumulator.
module sumadorCompletoN #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   assign {cout, s} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/multiplicador_secuencial_n.sv
// Iterative radix-2 shift-add multiplier, unsigned or two's-complement per operation.
// One WIDTH+1 adder is reused over WIDTH cycles; result sign is applied at the end.
module multiplicador_secuencial_n
   import mult_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   multiplicando,
   input  logic [WIDTH-1:0]   multiplicador,
   output logic [2*WIDTH-1:0] res,
   output logic               ovf,
   output logic               busy,
   output logic               done
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam int PW    = 2 * WIDTH;

   state_t state, state_next;

   logic [PW-1:0]    acc;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic             neg_res, mode_q;
   logic [CNT_W-1:0] cnt;

   logic             accept, last_step;
   logic [WIDTH-1:0] addend;
   logic [WIDTH:0]   sum;
   logic             carry_unused, lsb_unused;
   logic [PW-1:0]    acc_next, prod_final;
   logic             ovf_final;
   logic [PW-1:0]    hi_zero_mask_unused;

   logic [WIDTH-1:0]        mag_a_in, mag_b_in;
   logic [MAX_W-WIDTH-1:0]  mag_a_unused, mag_b_unused;
   logic [PW-1:0]           prod_neg;
   logic [2*MAX_W-PW-1:0]   prod_neg_unused;

   assign accept    = start && (state != CALC);
   assign last_step = (state == CALC) && (cnt == CNT_W'(WIDTH - 1));

   // NOTE: sequential state uses non-blocking assignments so every register sees
   // pre-edge values; blocking here would make results depend on statement order.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: every output of this block gets a default before the case, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: if (start) state_next = CALC;
         CALC: begin
            busy = 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = start ? CALC : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign {mag_a_unused, mag_a_in} =
      magnitude(MAX_W'(multiplicando), signed_mode & multiplicando[WIDTH-1]);
   assign {mag_b_unused, mag_b_in} =
      magnitude(MAX_W'(multiplicador), signed_mode & multiplicador[WIDTH-1]);

   assign addend = mag_b[0] ? mag_a : '0;

   sumadorCompletoN #(.WIDTH(WIDTH + 1)) u_acc_add (
      .a    ({1'b0, acc[PW-1:WIDTH]}),
      .b    ({1'b0, addend}),
      .cin  (1'b0),
      .s    (sum),
      .cout (carry_unused)
   );

   // The accumulator LSB is shifted out each cycle and never read.
   assign lsb_unused = acc[0];
   assign acc_next   = {sum, acc[WIDTH-1:1]};

   assign {prod_neg_unused, prod_neg} = negate((2*MAX_W)'(acc_next));
   assign prod_final = neg_res ? prod_neg : acc_next;

   always_comb begin
      hi_zero_mask_unused = '0;
      if (mode_q)
         ovf_final = !((&prod_final[PW-1:WIDTH-1]) || !(|prod_final[PW-1:WIDTH-1]));
      else
         ovf_final = |prod_final[PW-1:WIDTH];
   end

   // NOTE: all datapath registers are reset so an aborted operation leaves no stale
   // result behind; there are no memories here that would need to skip reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc     <= '0;
         mag_a   <= '0;
         mag_b   <= '0;
         neg_res <= 1'b0;
         mode_q  <= 1'b0;
         cnt     <= '0;
         res     <= '0;
         ovf     <= 1'b0;
      end else if (accept) begin
         acc     <= '0;
         mag_a   <= mag_a_in;
         mag_b   <= mag_b_in;
         neg_res <= signed_mode & (multiplicando[WIDTH-1] ^ multiplicador[WIDTH-1]);
         mode_q  <= signed_mode;
         cnt     <= '0;
      end else if (state == CALC) begin
         acc   <= acc_next;
         mag_b <= {1'b0, mag_b[WIDTH-1:1]};
         cnt   <= cnt + CNT_W'(1);
         if (last_step) begin
            res <= prod_final;
            ovf <= ovf_final;
         end
      end
   end

endmodule

// File: tb/tb_multiplicador_secuencial_n.sv
// Scoreboard bench for multiplicador_secuencial_n (WIDTH=4): driver pushes expected
// results on each accepted start; a negedge monitor pops and compares on done.
module tb_multiplicador_secuencial_n;

   localparam int W = 4;

   logic           clk = 1'b0;
   logic           rst, start, signed_mode;
   logic [W-1:0]   a, b;
   logic [2*W-1:0] res;
   logic           ovf, busy, done;

   multiplicador_secuencial_n #(.WIDTH(W)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .signed_mode   (signed_mode),
      .multiplicando (a),
      .multiplicador (b),
      .res           (res),
      .ovf           (ovf),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2*W-1:0] res;
      logic           ovf;
      int             cyc;
   } exp_t;

   typedef struct {
      logic           sm;
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] res;
      logic           ovf;
   } vec_t;

   exp_t sb[$];
   exp_t e;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   int   dones    = 0;
   int   d0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      else
         n_pass++;
   endtask

   // Monitor: one pop per done pulse, plus latency and exclusivity checks.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         dones++;
         check("busy_done_excl", {31'b0, busy}, 32'd0);
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_done: got done with empty scoreboard (t=%0t)", $time);
         end else begin
            e = sb.pop_front();
            check("res", {24'b0, res}, {24'b0, e.res});
            check("ovf", {31'b0, ovf}, {31'b0, e.ovf});
            check("latency", cyc - e.cyc, W);
         end
      end
   end

   task automatic issue(input logic sm, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic [2*W-1:0] er, input logic eo);
      @(negedge clk);
      start = 1'b1; signed_mode = sm; a = aa; b = bb;
      @(posedge clk); #1;
      sb.push_back('{er, eo, cyc});
      start = 1'b0;
      check("busy_after_start", {31'b0, busy}, 32'd1);
   endtask

   task automatic wait_done(input int target);
      for (int i = 0; i < 30; i++) begin
         if (dones >= target) break;
         @(negedge clk); #1;
      end
      check("done_count", dones, target);
   endtask

   task automatic run_op(input vec_t v);
      int tgt;
      tgt = dones + 1;
      issue(v.sm, v.a, v.b, v.res, v.ovf);
      wait_done(tgt);
   endtask

   vec_t vecs[7] = '{
      '{1'b0, 4'd13, 4'd11, 8'h8F, 1'b1},
      '{1'b0, 4'd3,  4'd2,  8'h06, 1'b0},
      '{1'b1, 4'hD,  4'h5,  8'hF1, 1'b1},
      '{1'b1, 4'hE,  4'h3,  8'hFA, 1'b0},
      '{1'b1, 4'h8,  4'h8,  8'h40, 1'b1},
      '{1'b1, 4'h8,  4'h1,  8'hF8, 1'b0},
      '{1'b0, 4'h0,  4'hF,  8'h00, 1'b0}
   };

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_res",  {24'b0, res}, 32'd0);
      check("rst_ovf",  {31'b0, ovf}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      @(negedge clk); rst = 1'b0;

      foreach (vecs[i]) run_op(vecs[i]);

      // start and operand changes while busy must be ignored
      d0 = dones;
      issue(1'b0, 4'd5, 4'd6, 8'h1E, 1'b1);
      @(negedge clk);
      start = 1'b1; signed_mode = 1'b1; a = 4'hF; b = 4'h7;
      repeat (2) @(negedge clk);
      start = 1'b0;
      wait_done(d0 + 1);
      repeat (8) @(negedge clk);
      check("ignored_start_dones", dones, d0 + 1);

      // start held high: accepted again in DONE every W+1 cycles
      d0 = dones;
      @(negedge clk);
      start = 1'b1; signed_mode = 1'b0; a = 4'd9; b = 4'd9;
      @(posedge clk); #1;
      sb.push_back('{8'h51, 1'b1, cyc});
      @(negedge clk);
      signed_mode = 1'b1; a = 4'd2; b = 4'd7;
      repeat (W + 1) @(posedge clk);
      #1;
      sb.push_back('{8'h0E, 1'b1, cyc});
      check("b2b_busy", {31'b0, busy}, 32'd1);
      @(negedge clk);
      signed_mode = 1'b1; a = 4'h8; b = 4'h8;
      repeat (W + 1) @(posedge clk);
      #1;
      sb.push_back('{8'h40, 1'b1, cyc});
      @(negedge clk);
      start = 1'b0;
      wait_done(d0 + 3);

      // reset in the 2nd CALC cycle aborts the operation
      d0 = dones;
      @(negedge clk);
      start = 1'b1; signed_mode = 1'b0; a = 4'd7; b = 4'd7;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_res",  {24'b0, res}, 32'd0);
      check("abort_ovf",  {31'b0, ovf}, 32'd0);
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_done", {31'b0, done}, 32'd0);
      @(negedge clk); rst = 1'b0;
      repeat (8) @(negedge clk);
      check("abort_no_done", dones, d0);

      run_op('{1'b0, 4'd7, 4'd7, 8'h31, 1'b1});

      check("scoreboard_empty", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/multiplicador_secuencial_n.md
Name: multiplicador_secuencial_n

Overview:
- Iterative radix-2 shift-add multiplier with a start/busy/done handshake.
- Parametrised in WIDTH and selectable per operation between unsigned and two's-complement signed multiplication.
- Returns the full 2*WIDTH-bit product plus an overflow flag for consumers that keep only WIDTH bits.
- Replaces the fully combinational array multiplier where area matters more than latency: one adder is reused over WIDTH cycles.

Parameters:
- WIDTH, 4, operand width in bits; legal range is 2 or more. The product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new multiplication; sampled only when busy=0.
- signed_mode  input  1  1 = operands are two's complement, 0 = unsigned; captured with start.
- multiplicando  input  WIDTH  operand A; captured with start.
- multiplicador  input  WIDTH  operand B; captured with start.
- res  output  2*WIDTH  product; valid from the done cycle and held until the next accepted start completes.
- ovf  output  1  product does not fit in WIDTH bits (see rules); valid and held together with res.
- busy  output  1  multiplication in progress.
- done  output  1  one-cycle pulse, result ready.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; res=0, ovf=0, busy=0, done=0; counter and internal registers cleared. A reset during CALC aborts the operation: no done pulse and res=0.
- FSM states: IDLE, CALC, DONE.
- IDLE, start=1: capture both operands, signed_mode and the result sign (sA XOR sB in signed mode, 0 otherwise). Convert each operand to a WIDTH-bit unsigned magnitude (absolute value in signed mode; -2^(WIDTH-1) maps to 2^(WIDTH-1)). Clear the 2*WIDTH accumulator, counter=0, go to CALC.
- CALC, each cycle:
  - if the current multiplier LSB is 1, add the magnitude of A into the upper WIDTH+1 bits of the accumulator;
  - shift the accumulator right by one and consume one multiplier bit;
  - increment the counter.
  - After exactly WIDTH cycles go to DONE.
- Entering DONE: res = magnitude product, negated (two's complement over 2*WIDTH bits) if the result sign is 1. Compute ovf in the same cycle.
- DONE lasts exactly one cycle: done=1, then go to IDLE.
- start is also accepted in DONE. It is captured exactly as in IDLE and the next state is CALC, not IDLE.
- Latency: start sampled at edge E0 → busy=1 for exactly WIDTH cycles → res/ovf update and done=1 in cycle WIDTH+1 after E0. A new result is available every WIDTH+1 cycles at maximum throughput.
- start while busy=1 is ignored: no queueing, and operand changes have no effect.
- busy=1 only in CALC; done=1 only in DONE. busy and done are never high together.
- ovf rules:
  - unsigned: ovf = (res[2W-1:W] != 0).
  - signed: ovf = 1 unless res[2W-1:W-1] is all zeros or all ones.
- Zero operands follow the normal WIDTH-cycle path (no early exit). A negative zero never appears: negating 0 yields 0.
- The internal adder carry-out is unused. The magnitude product fits in 2*WIDTH bits by construction.

Decomposition:
- Shared package mult_pkg holds:
  - the state enum typedef (IDLE, CALC, DONE);
  - a function for the WIDTH-bit magnitude and 2*WIDTH-bit two's-complement negate;
  - counter width localparam = $clog2(WIDTH+1).
- Sub-module: one instance of the existing sumadorCompletoN with WIDTH=WIDTH+1 performs the per-cycle accumulate. No other sub-modules.

Test Plan (WIDTH=4):
- Unsigned 13×11 → busy high 4 cycles, then done pulse with res=8'h8F (143), ovf=1. Then 3×2 → res=8'h06, ovf=0.
- Signed -3×5 (4'hD, 4'h5) → res=8'hF1 (-15), ovf=1. Signed -2×3 → res=8'hFA, ovf=0.
- Signed corner -8×-8 → res=8'h40, ovf=1. Signed -8×1 → res=8'hF8, ovf=0. Unsigned 0×15 → res=8'h00 after the full 4-cycle latency.
- Change operands and pulse start while busy=1 → ignored; result equals the first operands; exactly one done pulse.
- Hold start=1 continuously with new operands each op → done every 5 cycles, back-to-back start accepted in DONE, each res correct.
- Assert rst in the 2nd CALC cycle of 7×7 → next cycle res=0, busy=0, done=0, ovf=0, state IDLE; no done pulse follows. A following 7×7 gives 8'h31.
